spi_tx_arbiter: RTL

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

---
 rtl/spi_tx_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin arbiter that lets NUM_REQ command requesters
// share one SPI byte transmitter, one whole packet at a time.
//
// Handshake (requester side): a requester holds req_valid/req_byte/req_last
// stable until it sees its req_ack bit high for one cycle, then advances to
// its next byte. The ack is registered, so it appears in the same cycle as
// write and is not followed by another ack for at least three cycles.
// Handshake (transmitter side): write pulses for one cycle with byte_send;
// the transmitter raises busy within one cycle and drops it when done.
module spi_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0][7:0]      req_byte,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ack,
  input  logic                         busy,
  output logic                         write,
  output logic [7:0]                   byte_send,
  output logic                         grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         abort,
  output logic [1:0]                   state_dbg
);

  localparam int IW = $clog2(NUM_REQ);
  localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GUARD = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state;
  state_t               state_n;
  logic                 last_r;
  logic                 last_n;
  logic [7:0]           cnt;
  logic [7:0]           cnt_n;
  logic [7:0]           cnt_inc;
  logic [IW-1:0]        rr_ptr;
  logic [IW-1:0]        rr_n;
  logic                 write_n;
  logic [NUM_REQ-1:0]   ack_n;
  logic                 abort_n;
  logic                 gv_n;
  logic [IW-1:0]        gid_n;
  logic [7:0]           bs_n;

  logic                 found;
  logic [IW-1:0]        sel;

  assign state_dbg = state;

  // Saturating increment of the idle counter.
  assign cnt_inc = (cnt == 8'hFF) ? cnt : cnt + 8'd1;

  // Round-robin pick: first valid requester scanning upward from rr_ptr+1.
  always_comb begin
    int unsigned   idx;
    logic [IW-1:0] cand;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(rr_ptr) + i) % NUM_REQ;
      cand = IW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n = state;
    write_n = 1'b0;
    ack_n   = '0;
    abort_n = 1'b0;
    gv_n    = grant_valid;
    gid_n   = grant_id;
    bs_n    = byte_send;
    last_n  = last_r;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    case (state)
      IDLE: begin
        cnt_n = 8'd0;
        if (found) begin
          gv_n    = 1'b1;
          gid_n   = sel;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (req_valid[grant_id]) begin
          // A busy transmitter stalls the byte without counting as idle.
          if (!busy) begin
            write_n         = 1'b1;
            ack_n[grant_id] = 1'b1;
            bs_n            = req_byte[grant_id];
            last_n          = req_last[grant_id];
            cnt_n           = 8'd0;
            state_n         = GUARD;
          end
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc >= TIMEOUT_8) begin
            abort_n = 1'b1;
            gv_n    = 1'b0;
            rr_n    = grant_id;
            cnt_n   = 8'd0;
            state_n = IDLE;
          end
        end
      end
      GUARD: begin
        // Give the transmitter one cycle to raise busy before it is sampled.
        state_n = DRAIN;
      end
      DRAIN: begin
        if (!busy) begin
          if (last_r) begin
            gv_n    = 1'b0;
            rr_n    = grant_id;
            cnt_n   = 8'd0;
            state_n = IDLE;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops any grant in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      write       <= 1'b0;
      req_ack     <= '0;
      abort       <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      byte_send   <= 8'h00;
      last_r      <= 1'b0;
      cnt         <= 8'd0;
      rr_ptr      <= IW'(NUM_REQ - 1);
    end else begin
      state       <= state_n;
      write       <= write_n;
      req_ack     <= ack_n;
      abort       <= abort_n;
      grant_valid <= gv_n;
      grant_id    <= gid_n;
      byte_send   <= bs_n;
      last_r      <= last_n;
      cnt         <= cnt_n;
      rr_ptr      <= rr_n;
    end
  end

endmodule
